// File: rtl/sram_ctrl_pkg.sv
// Shared types and constants for the 16-bit external SRAM controller.
package sram_ctrl_pkg;

    localparam int unsigned SRAM_DW           = 16;
    localparam int unsigned DEFAULT_BASE_ADDR = 1024;
    localparam int unsigned DEFAULT_SRAM_AW   = 18;

    typedef enum logic [1:0] {
        IDLE,
        LOW,
        HIGH,
        DONE
    } state_e;

endpackage

// File: rtl/sram_phase_counter.sv
// Loadable down-counter that times one halfword phase; last flags the final cycle.
module sram_phase_counter #(
    parameter int unsigned CW = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    output logic          last
);

    logic [CW-1:0] count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_val;
        end else if (count_q != '0) begin
            count_q <= count_q - 1'b1;
        end
    end

    assign last = (count_q == CW'(1));

endmodule

// File: rtl/sram_controller.sv
// Splits 32-bit MEM-stage accesses into two halfword SRAM phases, stalling via ready.
// Optional address bounds check enabled by defining SRAM_CTRL_BOUNDS_CHECK_EN.
module sram_controller
    import sram_ctrl_pkg::*;
#(
    parameter int unsigned BASE_ADDR    = DEFAULT_BASE_ADDR,
    parameter int unsigned PHASE_CYCLES = 3,
    parameter int unsigned SRAM_AW      = DEFAULT_SRAM_AW
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               memRead,
    input  logic               memWrite,
    input  logic [31:0]        address,
    input  logic [31:0]        writeData,
    output logic [31:0]        readData,
    output logic               ready,
    output logic [SRAM_AW-1:0] sramAddr,
    output logic [SRAM_DW-1:0] sramDqOut,
    input  logic [SRAM_DW-1:0] sramDqIn,
    output logic               sramDqOe,
    output logic               sramWeN
`ifdef SRAM_CTRL_BOUNDS_CHECK_EN
    ,
    output logic               addrError
`endif
);

    localparam int unsigned CW = $clog2(PHASE_CYCLES + 1);
    localparam int unsigned WW = SRAM_AW - 1;

    state_e             state_q, state_d;
    logic               is_wr_q, is_wr_d;
    logic [WW-1:0]      word_q, word_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [31:0]        off;
    logic               req;
    logic               cnt_load;
    logic               last;
    logic [SRAM_AW-1:0] addr_d;
    logic [SRAM_DW-1:0] dq_d;
    logic               oe_d;
    logic               wen_d;

    assign req = memRead | memWrite;
    assign off = address - BASE_ADDR;

`ifdef SRAM_CTRL_BOUNDS_CHECK_EN
    logic oob;
    logic unused_off;
    assign oob        = |off[31:SRAM_AW+1];
    assign unused_off = ^off[1:0];
`else
    logic unused_off;
    assign unused_off = ^{off[31:SRAM_AW+1], off[1:0]};
`endif

    sram_phase_counter #(
        .CW(CW)
    ) u_phase_counter (
        .clk     (clk),
        .rst     (rst),
        .load    (cnt_load),
        .load_val(CW'(PHASE_CYCLES)),
        .last    (last)
    );

    always_comb begin
        state_d  = state_q;
        is_wr_d  = is_wr_q;
        word_d   = word_q;
        wdata_d  = wdata_q;
        cnt_load = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req) begin
                    // Write wins when both strobes are up.
                    is_wr_d = memWrite;
                    word_d  = off[SRAM_AW:2];
                    wdata_d = writeData;
`ifdef SRAM_CTRL_BOUNDS_CHECK_EN
                    if (oob) begin
                        state_d = DONE;
                    end else begin
                        state_d  = LOW;
                        cnt_load = 1'b1;
                    end
`else
                    state_d  = LOW;
                    cnt_load = 1'b1;
`endif
                end
            end
            LOW: begin
                if (last) begin
                    state_d  = HIGH;
                    cnt_load = 1'b1;
                end
            end
            HIGH: begin
                if (last) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Pad outputs are registered from the next state so they line up with the phase cycles.
    always_comb begin
        addr_d = sramAddr;
        dq_d   = sramDqOut;
        oe_d   = 1'b0;
        wen_d  = 1'b1;
        if (state_d == LOW || state_d == HIGH) begin
            addr_d = {word_d, state_d == HIGH};
            dq_d   = (state_d == HIGH) ? wdata_d[31:16] : wdata_d[15:0];
            oe_d   = is_wr_d;
            wen_d  = ~is_wr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            is_wr_q   <= 1'b0;
            word_q    <= '0;
            wdata_q   <= '0;
            readData  <= '0;
            sramAddr  <= '0;
            sramDqOut <= '0;
            sramDqOe  <= 1'b0;
            sramWeN   <= 1'b1;
        end else begin
            state_q   <= state_d;
            is_wr_q   <= is_wr_d;
            word_q    <= word_d;
            wdata_q   <= wdata_d;
            sramAddr  <= addr_d;
            sramDqOut <= dq_d;
            sramDqOe  <= oe_d;
            sramWeN   <= wen_d;
            if (!is_wr_q && last) begin
                if (state_q == LOW) begin
                    readData[15:0] <= sramDqIn;
                end else if (state_q == HIGH) begin
                    readData[31:16] <= sramDqIn;
                end
            end
        end
    end

`ifdef SRAM_CTRL_BOUNDS_CHECK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            addrError <= 1'b0;
        end else begin
            addrError <= (state_q == IDLE) && req && oob;
        end
    end
`endif

    assign ready = ((state_q == IDLE) && !req) || (state_q == DONE);

endmodule

// File: tb/tb_sram_controller.sv
// Scoreboard bench for sram_controller: word-level memory model plus a halfword SRAM model.
module tb_sram_controller;

    localparam int unsigned BASE = 1024;
    localparam int unsigned P    = 3;
    localparam int unsigned AW   = 18;
    localparam int unsigned NW   = 1 << (AW - 1);

    logic          clk;
    logic          rst;
    logic          memRead;
    logic          memWrite;
    logic [31:0]   address;
    logic [31:0]   writeData;
    logic [31:0]   readData;
    logic          ready;
    logic [AW-1:0] sramAddr;
    logic [15:0]   sramDqOut;
    logic [15:0]   sramDqIn;
    logic          sramDqOe;
    logic          sramWeN;
`ifdef SRAM_CTRL_BOUNDS_CHECK_EN
    logic          addrError;
`endif

    sram_controller #(
        .BASE_ADDR   (BASE),
        .PHASE_CYCLES(P),
        .SRAM_AW     (AW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .memRead  (memRead),
        .memWrite (memWrite),
        .address  (address),
        .writeData(writeData),
        .readData (readData),
        .ready    (ready),
        .sramAddr (sramAddr),
        .sramDqOut(sramDqOut),
        .sramDqIn (sramDqIn),
        .sramDqOe (sramDqOe),
        .sramWeN  (sramWeN)
`ifdef SRAM_CTRL_BOUNDS_CHECK_EN
        ,
        .addrError(addrError)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Halfword-wide board SRAM.
    logic [15:0] sram_mem [0:(1<<AW)-1];
    assign sramDqIn = sram_mem[sramAddr];
    always @(posedge clk) if (!sramWeN) sram_mem[sramAddr] <= sramDqOut;

    // Word-level reference memory.
    logic [31:0] exp_mem [0:NW-1];

    typedef struct {
        bit          wr;
        bit          oob;
        bit          upd;
        logic [16:0] word;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          lat;
    } txn_t;

    txn_t sb[$];
    int   total;
    int   bad;

    function automatic logic [15:0] pat(input int unsigned a);
        return 16'(a * 40503 + 23130);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Issue one request; hold > 0 drops the request after that many cycles.
    task automatic do_txn(input bit rd, input bit wr, input logic [31:0] addr,
                          input logic [31:0] data, input int hold);
        txn_t        t;
        logic [31:0] off;
        int          n;
        off     = addr - BASE;
        t.word  = 17'((off >> 2) % NW);
        t.wr    = wr;
        t.wdata = data;
`ifdef SRAM_CTRL_BOUNDS_CHECK_EN
        t.oob   = (off >= (32'd1 << (AW + 1)));
`else
        t.oob   = 1'b0;
`endif
        t.lat   = t.oob ? 1 : 2 * P + 1;
        t.upd   = !wr && !t.oob;
        t.rdata = t.upd ? exp_mem[t.word] : 32'h0;
        if (wr && !t.oob) exp_mem[t.word] = data;
        sb.push_back(t);
        memRead   = rd;
        memWrite  = wr;
        address   = addr;
        writeData = data;
        n = 0;
        forever begin
            @(negedge clk);
            if (ready) break;
            n++;
            if (n > 40) begin
                total++;
                bad++;
                $display("FAIL ready_timeout: got no ready want ready within 40 cycles");
                break;
            end
            @(posedge clk);
            #1;
            if (hold > 0 && n >= hold) begin
                memRead  = 1'b0;
                memWrite = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        memRead  = 1'b0;
        memWrite = 1'b0;
    endtask

    // Monitor: pops the scoreboard when the DUT signals completion.
    bit          active;
    int          cyc;
    txn_t        cur;
    logic [31:0] cur_rdata;
    logic [31:0] exp_r;
    logic [17:0] exp_ha;

    initial begin
        active    = 1'b0;
        cyc       = 0;
        cur_rdata = '0;
    end

    always @(negedge clk) begin
        if (rst) begin
            active    = 1'b0;
            cur_rdata = '0;
            sb.delete();
        end else if (!active) begin
            if (memRead || memWrite) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL sb_empty: got request want queued transaction");
                end else begin
                    active = 1'b1;
                    cyc    = 0;
                    cur    = sb[0];
                    check("ready_cyc0", ready, 1'b0);
                end
            end else begin
                check("rdata_hold", readData, cur_rdata);
                check("idle_strobes", {sramWeN, sramDqOe}, 2'b10);
            end
        end else begin
            cyc++;
            if (ready) begin
                check("latency", cyc, cur.lat);
                exp_r = cur.upd ? cur.rdata : cur_rdata;
                check("rdata_done", readData, exp_r);
                cur_rdata = exp_r;
                check("done_strobes", {sramWeN, sramDqOe}, 2'b10);
`ifdef SRAM_CTRL_BOUNDS_CHECK_EN
                check("addr_error", addrError, cur.oob);
`endif
                void'(sb.pop_front());
                active = 1'b0;
            end else if (cyc > 2 * P + 4) begin
                check("latency_bound", cyc, cur.lat);
                void'(sb.pop_front());
                active = 1'b0;
            end else if (!cur.oob && cyc <= 2 * P) begin
                exp_ha = {cur.word, cyc > P};
                check("phase_ctl", {sramAddr, sramDqOe, sramWeN}, {exp_ha, cur.wr, !cur.wr});
                if (cur.wr) begin
                    check("phase_dq", sramDqOut,
                          (cyc > P) ? cur.wdata[31:16] : cur.wdata[15:0]);
                end
            end
        end
    end

    initial begin
        total = 0;
        bad   = 0;
        for (int i = 0; i < (1 << AW); i++) sram_mem[i] = pat(i);
        for (int w = 0; w < NW; w++) exp_mem[w] = {pat(2 * w + 1), pat(2 * w)};
        sram_mem[2] = 16'h1234;
        sram_mem[3] = 16'hABCD;
        exp_mem[1]  = 32'hABCD1234;

        rst       = 1'b1;
        memRead   = 1'b0;
        memWrite  = 1'b0;
        address   = '0;
        writeData = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_readData", readData, 32'h0);
        check("rst_sramAddr", sramAddr, 18'h0);
        check("rst_sramDqOut", sramDqOut, 16'h0);
        check("rst_strobes", {sramWeN, sramDqOe}, 2'b10);
        check("rst_ready", ready, 1'b1);
        @(posedge clk);
        #1;
        rst = 1'b0;

        do_txn(1'b0, 1'b1, 32'd1024, 32'hDEADBEEF, 0);
        do_txn(1'b1, 1'b0, 32'd1028, 32'h0, 0);
        repeat (2) begin @(posedge clk); #1; end
        do_txn(1'b1, 1'b0, 32'd1024, 32'h0, 0);
        do_txn(1'b1, 1'b1, 32'd1024, 32'h5, 0);
        do_txn(1'b1, 1'b0, 32'd1024, 32'h0, 0);
        do_txn(1'b0, 1'b1, 32'd1032, 32'hCAFEF00D, 2);
        do_txn(1'b1, 1'b0, 32'd1032, 32'h0, 2);

        // Reset in cycle 2 of a write: only the low half reaches the SRAM.
        begin
            txn_t t;
            t.wr = 1'b1; t.oob = 1'b0; t.upd = 1'b0; t.word = 17'd4;
            t.wdata = 32'h11112222; t.rdata = '0; t.lat = 2 * P + 1;
            sb.push_back(t);
            exp_mem[4][15:0] = 16'h2222;
        end
        memWrite  = 1'b1;
        address   = 32'd1040;
        writeData = 32'h11112222;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst      = 1'b1;
        memWrite = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("abort_strobes", {sramWeN, sramDqOe}, 2'b10);
        check("abort_ready", ready, 1'b1);
        check("abort_readData", readData, 32'h0);
        @(posedge clk); #1;
        do_txn(1'b1, 1'b0, 32'd1040, 32'h0, 0);

        for (int i = 0; i < 40; i++) begin
            logic [31:0] a;
            int unsigned op;
            int          hold;
            int unsigned gap;
            a = BASE + 4 * $urandom_range(0, 31) + $urandom_range(0, 3);
`ifndef SRAM_CTRL_BOUNDS_CHECK_EN
            if ($urandom_range(0, 7) == 0) a = BASE - 4 * (1 + $urandom_range(0, 3));
`endif
            op   = $urandom_range(0, 2);
            hold = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
            do_txn(op != 1, op != 0, a, $urandom, hold);
            gap = $urandom_range(0, 2);
            repeat (gap) begin @(posedge clk); #1; end
        end

`ifdef SRAM_CTRL_BOUNDS_CHECK_EN
        do_txn(1'b0, 1'b1, 32'd1024 + (32'd1 << 19), 32'h77778888, 0);
        do_txn(1'b1, 1'b0, 32'd1024 + (32'd1 << 19), 32'h0, 0);
        do_txn(1'b1, 1'b0, 32'd1024, 32'h0, 0);
`endif

        repeat (3) begin @(posedge clk); #1; end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sram_controller.md
Name: sram_controller

Overview:
- Sequences the 16-bit external SRAM on behalf of the MEM stage, driven by the memRead/memWrite pair from the control unit.
- Splits each 32-bit word access into two halfword phases with programmable wait states.
- Drives ready low to freeze the pipeline until the access completes.
- Sits between the MEM stage and the board SRAM pins; the tri-state pad itself is outside the block.

Parameters:
- BASE_ADDR, 1024: byte address mapped to SRAM word 0.
- PHASE_CYCLES, 3: cycles each halfword phase holds address/control (>=1).
- SRAM_AW, 18: SRAM halfword address width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- memRead  in  1  read request, held until ready.
- memWrite  in  1  write request, held until ready.
- address  in  32  byte address from ALU (ADD result).
- writeData  in  32  store data.
- readData  out  32  last completed read word.
- ready  out  1  1 = no stall; 0 = freeze pipeline.
- sramAddr  out  SRAM_AW  halfword address.
- sramDqOut  out  16  write data to pad.
- sramDqIn  in  16  read data from pad.
- sramDqOe  out  1  pad output enable.
- sramWeN  out  1  active-low write enable.

Behaviour:
- Reset values: readData=0, sramAddr=0, sramDqOut=0, sramDqOe=0, sramWeN=1, state=IDLE, phase counter=0. ready follows the combinational rule below.
- Reset mid-operation aborts immediately: next cycle is IDLE, sramWeN=1, sramDqOe=0.
- ready = (state==IDLE && !memRead && !memWrite) || state==DONE.
- Address mapping:
  - off = address - BASE_ADDR (32-bit, wraps).
  - word = off[SRAM_AW:2]; off[1:0] ignored.
  - LOW phase sramAddr = {word,1'b0}; HIGH phase sramAddr = {word,1'b1}.
- FSM states IDLE, LOW, HIGH, DONE:
  - IDLE: on memWrite or memRead, latch address/writeData/op and go to LOW. If both are high, it is a write and readData is unchanged.
  - LOW: stays PHASE_CYCLES cycles, then goes to HIGH.
  - HIGH: stays PHASE_CYCLES cycles, then goes to DONE.
  - DONE: one cycle with ready=1, then IDLE.
- Latency: request first seen in cycle 0 gives ready=1 in cycle 2*PHASE_CYCLES+1. Default: cycle 7, 8 cycles of stall-inclusive request.
- Write phases:
  - sramDqOe=1 and sramWeN=0 for every cycle of the phase.
  - sramDqOut = latched data[15:0] in LOW, [31:16] in HIGH.
- Read phases:
  - sramDqOe=0, sramWeN=1.
  - sramDqIn is sampled in the last cycle of LOW into readData[15:0], and of HIGH into readData[31:16].
  - Upper half is updated at the end of HIGH; readData is fully valid from DONE on.
- Request deasserted mid-transaction: the transaction completes anyway (committed once LOW is entered).
- Back-to-back requests: a request in the cycle after DONE starts a new transaction; no idle gap is required beyond IDLE itself.
- In IDLE and DONE, sramWeN=1 and sramDqOe=0.

Optional Feature:
- SRAM_CTRL_BOUNDS_CHECK_EN defined:
  - Adds output port addrError (1 bit, reset 0).
  - A request whose off >= 2**(SRAM_AW+1) bytes skips LOW/HIGH and goes IDLE->DONE, with no SRAM strobes and readData unchanged.
  - addrError=1 in that DONE cycle, 0 otherwise.
- Undefined: no port; addresses wrap silently into the SRAM range.

Decomposition:
- Package sram_ctrl_pkg holds:
  - state enum {IDLE, LOW, HIGH, DONE}
  - SRAM_DW=16 and the default BASE_ADDR and SRAM_AW constants.
- One sub-module, sram_phase_counter:
  - loadable down-counter with clear on rst.
  - asserts last when count==1; used by both phases.

Test Plan:
- Write address=1024, writeData=0xDEADBEEF, PHASE_CYCLES=3:
  - sramAddr=0 with sramDqOut=0xBEEF for 3 cycles, then sramAddr=1 with 0xDEAD for 3 cycles.
  - sramWeN low for those 6 cycles; ready=1 in cycle 7.
- Read address=1028 with the SRAM model returning 0x1234 at addr 2 and 0xABCD at addr 3:
  - readData=0xABCD1234 in DONE (cycle 7), held thereafter.
- Reset asserted in cycle 2 of a write:
  - next cycle sramWeN=1, sramDqOe=0, ready=1 with no request.
  - a subsequent read returns 0 until valid.
- memRead and memWrite both high, address=1024, data=0x5:
  - write performed, readData unchanged, ready at cycle 7.
- Request dropped after cycle 1:
  - all 6 phase cycles still occur; DONE still pulses ready.
- With SRAM_CTRL_BOUNDS_CHECK_EN, address=1024+2**19:
  - ready=1 and addrError=1 in cycle 1; sramWeN stays 1.
